// File: rtl/spi_tx_seq.sv
// Word sequencer for an SPI shift engine: queues words in a small FIFO and
// feeds them one at a time, with a fixed en-low gap between consecutive words.
module spi_tx_seq #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [BITS-1:0]        wr_data_i,
    input  logic                   fin_i,
    output logic                   en_o,
    output logic [BITS-1:0]        data2trans_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   busy_o,
    output logic                   ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [GW-1:0] GAP_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] GAP_INIT  = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            fin_d_q;
    logic            en_q, en_d;
    logic [BITS-1:0] data_q, data_d;
    logic            ovf_q;
    logic            wr_ok_s, pop_s, finr_s;

    // Room is judged on the registered count only; a same-cycle pop never frees a slot.
    assign wr_ok_s = wr_en_i && (count_q < CNT_FULL);
    assign finr_s  = fin_i && !fin_d_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != CNT_ZERO) state_d = ST_SEND;
                else                     state_d = ST_IDLE;
            end
            ST_SEND: begin
                if (finr_s) state_d = ST_GAP;
                else        state_d = ST_SEND;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_ZERO) begin
                    if (count_q != CNT_ZERO) state_d = ST_SEND;
                    else                     state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath decode: pop, enable, word and gap counter next values.
    always_comb begin
        pop_s     = 1'b0;
        en_d      = en_q;
        data_d    = data_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != CNT_ZERO) begin
                    pop_s  = 1'b1;
                    en_d   = 1'b1;
                    data_d = mem_q[rd_ptr_q];
                end else begin
                    en_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (finr_s) begin
                    en_d      = 1'b0;
                    gap_cnt_d = GAP_INIT;
                end else begin
                    en_d      = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_ZERO) begin
                    if (count_q != CNT_ZERO) begin
                        pop_s  = 1'b1;
                        en_d   = 1'b1;
                        data_d = mem_q[rd_ptr_q];
                    end else begin
                        en_d   = 1'b0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    // Occupancy bookkeeping.
    always_comb begin
        if (wr_ok_s && !pop_s)      count_d = count_q + CNT_ONE;
        else if (!wr_ok_s && pop_s) count_d = count_q - CNT_ONE;
        else                        count_d = count_q;
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {BITS{1'b0}};
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= CNT_ZERO;
            gap_cnt_q <= GAP_ZERO;
            fin_d_q   <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= {BITS{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q   <= count_d;
            gap_cnt_q <= gap_cnt_d;
            fin_d_q   <= fin_i;
            en_q      <= en_d;
            data_q    <= data_d;
            ovf_q     <= wr_en_i && !wr_ok_s;
        end
    end

    assign en_o         = en_q;
    assign data2trans_o = data_q;
    assign count_o      = count_q;
    assign full_o       = (count_q == CNT_FULL);
    assign empty_o      = (count_q == CNT_ZERO);
    assign busy_o       = (state_q != ST_IDLE);
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_spi_tx_seq.sv
// Self-checking bench for spi_tx_seq: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_spi_tx_seq;

    localparam int DEPTH_P = 4;
    localparam int GAP_P   = 4;

    logic       clk, rst_n, wr_en, fin;
    logic [7:0] wr_data;
    logic       en_o, full_o, empty_o, busy_o, ovf_o;
    logic [7:0] data2trans_o;
    logic [2:0] count_o;
    logic [15:0] dut_vec;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    spi_tx_seq #(.BITS(8), .DEPTH(DEPTH_P), .GAP(GAP_P)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .fin_i(fin), .en_o(en_o), .data2trans_o(data2trans_o), .full_o(full_o),
        .empty_o(empty_o), .count_o(count_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    assign dut_vec = {en_o, data2trans_o, count_o, full_o, empty_o, busy_o, ovf_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of pending words, current word, and a phase
    // (0 idle, 1 sending, 2 waiting out the inter-word gap).
    bit [7:0] fifo_m[$];
    bit       en_m, ovf_m, fin_prev_m;
    bit [7:0] data_m;
    int       mode_m, gap_left_m;

    task automatic model_reset();
        fifo_m.delete();
        en_m = 0; ovf_m = 0; fin_prev_m = 0; data_m = 8'h00;
        mode_m = 0; gap_left_m = 0;
    endtask

    task automatic model_step();
        bit finr, start, acc;
        int sz;
        finr = fin && !fin_prev_m;
        fin_prev_m = fin;
        sz = fifo_m.size();
        acc = wr_en && (sz < DEPTH_P);
        ovf_m = wr_en && !acc;
        start = 0;
        if (mode_m == 0) begin
            start = (sz > 0);
        end else if (mode_m == 1) begin
            if (finr) begin en_m = 0; mode_m = 2; gap_left_m = GAP_P; end
        end else begin
            if (gap_left_m == 1) begin
                if (sz > 0) start = 1; else mode_m = 0;
            end else begin
                gap_left_m--;
            end
        end
        if (start) begin data_m = fifo_m.pop_front(); en_m = 1; mode_m = 1; end
        if (acc) fifo_m.push_back(wr_data);
    endtask

    function automatic logic [15:0] model_vec();
        int sz = fifo_m.size();
        return {en_m, data_m, 3'(sz), sz == DEPTH_P, sz == 0, mode_m != 0, ovf_m};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; fin = 1'b0;
        model_reset();
        #12;
        chk_cnt++;
        if (dut_vec !== 16'h0004) $display("FAIL reset_vals: got %h expected %h", dut_vec, 16'h0004);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (dut_vec !== model_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_single();
        wr_en = 1'b1; wr_data = 8'hAA; tick(); wr_en = 1'b0;
        chk_cnt++;
        if ({en_o, count_o} !== {1'b0, 3'd1}) $display("FAIL single_queued: got %b expected %b", {en_o, count_o}, {1'b0, 3'd1});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({en_o, data2trans_o} !== {1'b1, 8'hAA}) $display("FAIL single_latency: got %h expected %h", {en_o, data2trans_o}, {1'b1, 8'hAA});
        else pass_cnt++;
        tick(); tick();
        fin = 1'b1; tick(); fin = 1'b0;
        for (int i = 0; i < GAP_P; i++) begin
            chk_cnt++;
            if ({en_o, busy_o} !== 2'b01) $display("FAIL single_gap%0d: got %b expected %b", i, {en_o, busy_o}, 2'b01);
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if ({en_o, busy_o, data2trans_o} !== {2'b00, 8'hAA}) $display("FAIL single_idle_hold: got %h expected %h", {en_o, busy_o, data2trans_o}, {2'b00, 8'hAA});
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec !== model_vec()) $display("FAIL single_model: got %h expected %h", dut_vec, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_burst();
        logic [7:0] burst [4];
        int low;
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
        wr_en = 1'b1; wr_data = 8'h01; tick(); wr_en = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = burst[i]; tick();
        end
        chk_cnt++;
        if ({full_o, count_o} !== {1'b1, 3'd4}) $display("FAIL burst_full: got %b expected %b", {full_o, count_o}, {1'b1, 3'd4});
        else pass_cnt++;
        wr_data = 8'h55; tick(); wr_en = 1'b0;
        chk_cnt++;
        if ({ovf_o, full_o, count_o} !== {2'b11, 3'd4}) $display("FAIL burst_ovf: got %b expected %b", {ovf_o, full_o, count_o}, {2'b11, 3'd4});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({ovf_o, full_o} !== 2'b01) $display("FAIL burst_ovf_pulse: got %b expected %b", {ovf_o, full_o}, 2'b01);
        else pass_cnt++;
        fin = 1'b1; tick(); fin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            low = 0;
            while (en_o !== 1'b1 && low < 20) begin low++; tick(); end
            chk_cnt++;
            if (low != GAP_P) $display("FAIL burst_gap%0d: got %0d expected %0d", i, low, GAP_P);
            else pass_cnt++;
            chk_cnt++;
            if (data2trans_o !== burst[i]) $display("FAIL burst_word%0d: got %h expected %h", i, data2trans_o, burst[i]);
            else pass_cnt++;
            tick(); tick();
            fin = 1'b1; tick(); fin = 1'b0;
        end
        repeat (5) tick();
        chk_cnt++;
        if (dut_vec !== model_vec()) $display("FAIL burst_model: got %h expected %h", dut_vec, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_gap_write();
        wr_en = 1'b1; wr_data = 8'h5A; tick(); wr_en = 1'b0; tick(); tick();
        fin = 1'b1; tick(); fin = 1'b0;
        tick();
        wr_en = 1'b1; wr_data = 8'h3C; tick(); wr_en = 1'b0;
        chk_cnt++;
        if ({en_o, count_o} !== {1'b0, 3'd1}) $display("FAIL gapwr_queued: got %b expected %b", {en_o, count_o}, {1'b0, 3'd1});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (en_o !== 1'b0) $display("FAIL gapwr_still_low: got %b expected %b", en_o, 1'b0);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({en_o, data2trans_o} !== {1'b1, 8'h3C}) $display("FAIL gapwr_start: got %h expected %h", {en_o, data2trans_o}, {1'b1, 8'h3C});
        else pass_cnt++;
        tick(); fin = 1'b1; tick(); fin = 1'b0;
        repeat (5) tick();
        chk_cnt++;
        if (dut_vec !== model_vec()) $display("FAIL gapwr_model: got %h expected %h", dut_vec, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_fin_abuse();
        int rises, falls;
        logic prev;
        fin = 1'b1; rises = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (en_o === 1'b1) rises++;
        end
        chk_cnt++;
        if (rises != 0 || busy_o !== 1'b0) $display("FAIL finabuse_idle: got en_cycles=%0d busy=%b expected 0 0", rises, busy_o);
        else pass_cnt++;
        fin = 1'b0; tick();
        wr_en = 1'b1; wr_data = 8'h77; tick();
        wr_data = 8'h78; tick(); wr_en = 1'b0;
        chk_cnt++;
        if ({en_o, data2trans_o, count_o} !== {1'b1, 8'h77, 3'd1}) $display("FAIL finabuse_send: got %h expected %h", {en_o, data2trans_o, count_o}, {1'b1, 8'h77, 3'd1});
        else pass_cnt++;
        fin = 1'b1; rises = 0; falls = 0; prev = en_o;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (en_o && !prev) rises++;
            if (!en_o && prev) falls++;
            prev = en_o;
        end
        chk_cnt++;
        if (rises != 1 || falls != 1) $display("FAIL finabuse_held: got rises=%0d falls=%0d expected 1 1", rises, falls);
        else pass_cnt++;
        chk_cnt++;
        if ({en_o, data2trans_o} !== {1'b1, 8'h78}) $display("FAIL finabuse_next: got %h expected %h", {en_o, data2trans_o}, {1'b1, 8'h78});
        else pass_cnt++;
        fin = 1'b0; tick(); fin = 1'b1; tick(); fin = 1'b0;
        repeat (5) tick();
        chk_cnt++;
        if (dut_vec !== model_vec()) $display("FAIL finabuse_model: got %h expected %h", dut_vec, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_data = 8'hA1; tick(); wr_en = 1'b0; tick();
        wr_en = 1'b1; wr_data = 8'hB2; tick(); wr_en = 1'b0;
        fin = 1'b1; tick(); fin = 1'b0;
        tick(); tick(); tick();
        wr_en = 1'b1; wr_data = 8'hC3; tick(); wr_en = 1'b0;
        chk_cnt++;
        if ({count_o, en_o, data2trans_o} !== {3'd1, 1'b1, 8'hB2}) $display("FAIL b2b_swap: got %h expected %h", {count_o, en_o, data2trans_o}, {3'd1, 1'b1, 8'hB2});
        else pass_cnt++;
        tick(); fin = 1'b1; tick(); fin = 1'b0;
        repeat (3) tick();
        chk_cnt++;
        if ({en_o, count_o} !== {1'b0, 3'd1}) $display("FAIL b2b_gap: got %b expected %b", {en_o, count_o}, {1'b0, 3'd1});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({count_o, en_o, data2trans_o} !== {3'd0, 1'b1, 8'hC3}) $display("FAIL b2b_order: got %h expected %h", {count_o, en_o, data2trans_o}, {3'd0, 1'b1, 8'hC3});
        else pass_cnt++;
        fin = 1'b1; tick(); fin = 1'b0;
        repeat (5) tick();
        chk_cnt++;
        if (dut_vec !== model_vec()) $display("FAIL b2b_model: got %h expected %h", dut_vec, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic quiet;
        wr_en = 1'b1; wr_data = 8'h10; tick(); wr_en = 1'b0; tick();
        wr_en = 1'b1;
        wr_data = 8'h20; tick();
        wr_data = 8'h30; tick();
        wr_data = 8'h40; tick();
        wr_en = 1'b0;
        chk_cnt++;
        if ({en_o, count_o} !== {1'b1, 3'd3}) $display("FAIL rstmid_pre: got %b expected %b", {en_o, count_o}, {1'b1, 3'd3});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_cnt++;
        if (dut_vec !== 16'h0004) $display("FAIL rstmid_async: got %h expected %h", dut_vec, 16'h0004);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (en_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
        end
        chk_cnt++;
        if (quiet !== 1'b1) $display("FAIL rstmid_quiet: got %b expected %b", quiet, 1'b1);
        else pass_cnt++;
        wr_en = 1'b1; wr_data = 8'h66; tick(); wr_en = 1'b0; tick();
        chk_cnt++;
        if ({en_o, data2trans_o} !== {1'b1, 8'h66}) $display("FAIL rstmid_new: got %h expected %h", {en_o, data2trans_o}, {1'b1, 8'h66});
        else pass_cnt++;
        fin = 1'b1; tick(); fin = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
            fin     = ($urandom_range(0, 5) == 0);
            tick();
            chk_cnt++;
            if (dut_vec !== model_vec()) $display("FAIL random_cyc%0d: got %h expected %h", i, dut_vec, model_vec());
            else pass_cnt++;
        end
        wr_en = 1'b0; fin = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_gap_write();
        test_fin_abuse();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
